// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: PC, one-deep fetch register and next-PC selection.
// Redirects (exception, ERET, jump, branch) flush the fetch register to a NOP bubble.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0008
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        Branch_Taken,
    input  logic [15:0] Branch_Offset,
    input  logic        Jump,
    input  logic [25:0] Jump_Target,
    input  logic        Exc_Req,
    input  logic        Eret,
    input  logic [31:0] EPC_In,
    input  logic [31:0] Inst_In,
    output logic [31:0] Addr,
    output logic [31:0] IR,
    output logic [31:0] IR_PC,
    output logic        IR_Valid,
    output logic [31:0] Exc_PC,
    output logic [31:0] Fetch_Count
);

    typedef enum logic [2:0] {
        SRC_SEQ,
        SRC_HOLD,
        SRC_BR,
        SRC_JMP,
        SRC_ERET,
        SRC_EXC
    } src_e;

    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic        ir_valid;
    logic [31:0] fetch_count;

    src_e        src;
    logic [31:0] ir_pc_plus4;
    logic [31:0] br_disp;
    logic [31:0] br_target;
    logic [31:0] jmp_target;
    logic [31:0] eret_target;
    logic [31:0] redirect_pc;
    logic        redirect;
    logic        eret_ok;
    logic        jmp_ok;
    logic        br_ok;
    logic        unused_epc;

    // Control transfers belong to the instruction in IR, so a bubble cannot redirect.
    assign eret_ok = Eret & ir_valid;
    assign jmp_ok  = Jump & ir_valid;
    assign br_ok   = Branch_Taken & ir_valid;

    assign ir_pc_plus4 = ir_pc + 32'd4;
    assign br_disp     = {{14{Branch_Offset[15]}}, Branch_Offset, 2'b00};
    assign br_target   = ir_pc_plus4 + br_disp;
    assign jmp_target  = {ir_pc_plus4[31:28], Jump_Target, 2'b00};
    assign eret_target = {EPC_In[31:2], 2'b00};
    assign unused_epc  = ^EPC_In[1:0];

    always_comb begin
        src = SRC_SEQ;
        priority case (1'b1)
            Exc_Req: src = SRC_EXC;
            eret_ok: src = SRC_ERET;
            jmp_ok:  src = SRC_JMP;
            br_ok:   src = SRC_BR;
            Stall:   src = SRC_HOLD;
            default: src = SRC_SEQ;
        endcase
    end

    always_comb begin
        redirect    = 1'b1;
        redirect_pc = pc;
        unique case (src)
            SRC_EXC:  redirect_pc = EXC_VECTOR;
            SRC_ERET: redirect_pc = eret_target;
            SRC_JMP:  redirect_pc = jmp_target;
            SRC_BR:   redirect_pc = br_target;
            default:  redirect    = 1'b0;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc          <= RESET_PC;
            ir          <= 32'h0;
            ir_pc       <= 32'h0;
            ir_valid    <= 1'b0;
            fetch_count <= 32'h0;
        end else if (redirect) begin
            pc       <= redirect_pc;
            ir       <= 32'h0;
            ir_valid <= 1'b0;
        end else if (src == SRC_SEQ) begin
            pc          <= pc + 32'd4;
            ir          <= Inst_In;
            ir_pc       <= pc;
            ir_valid    <= 1'b1;
            fetch_count <= fetch_count + 32'd1;
        end
    end

    assign Addr        = {pc[31:2], 2'b00};
    assign IR          = ir;
    assign IR_PC       = ir_pc;
    assign IR_Valid    = ir_valid;
    assign Exc_PC      = ir_valid ? ir_pc : pc;
    assign Fetch_Count = fetch_count;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: a reference model queues the expected
// outputs for every edge; each scenario pops and compares them plus spot values.
module tb_inst_fetch_unit;

    logic        Clk;
    logic        Reset;
    logic        Stall;
    logic        Branch_Taken;
    logic [15:0] Branch_Offset;
    logic        Jump;
    logic [25:0] Jump_Target;
    logic        Exc_Req;
    logic        Eret;
    logic [31:0] EPC_In;
    logic [31:0] Inst_In;
    logic [31:0] Addr;
    logic [31:0] IR;
    logic [31:0] IR_PC;
    logic        IR_Valid;
    logic [31:0] Exc_PC;
    logic [31:0] Fetch_Count;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] ir;
        logic [31:0] ir_pc;
        logic        valid;
        logic [31:0] cnt;
        logic [31:0] exc_pc;
    } obs_t;

    obs_t sb[$];
    obs_t got;
    obs_t exp_o;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] m_pc, m_ir, m_irpc, m_cnt;
    logic        m_v;

    inst_fetch_unit dut (
        .Clk(Clk), .Reset(Reset), .Stall(Stall),
        .Branch_Taken(Branch_Taken), .Branch_Offset(Branch_Offset),
        .Jump(Jump), .Jump_Target(Jump_Target),
        .Exc_Req(Exc_Req), .Eret(Eret), .EPC_In(EPC_In),
        .Inst_In(Inst_In), .Addr(Addr), .IR(IR), .IR_PC(IR_PC),
        .IR_Valid(IR_Valid), .Exc_PC(Exc_PC), .Fetch_Count(Fetch_Count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return 32'h1000_0000 + {2'b00, a[31:2]};
    endfunction

    assign Inst_In = mem(Addr);

    task automatic clear_in();
        Reset = 0; Stall = 0; Branch_Taken = 0; Branch_Offset = 0;
        Jump = 0; Jump_Target = 0; Exc_Req = 0; Eret = 0; EPC_In = 0;
    endtask

    // Advance the model for the current inputs, queue the result, clock the DUT.
    task automatic step();
        logic [31:0] p4;
        obs_t e;
        p4 = m_irpc + 32'd4;
        if (Reset) begin
            m_pc = 32'h0; m_ir = 0; m_irpc = 0; m_v = 0; m_cnt = 0;
        end else if (Exc_Req) begin
            m_pc = 32'h8; m_ir = 0; m_v = 0;
        end else if (Eret && m_v) begin
            m_pc = EPC_In & 32'hFFFF_FFFC; m_ir = 0; m_v = 0;
        end else if (Jump && m_v) begin
            m_pc = {p4[31:28], Jump_Target, 2'b00}; m_ir = 0; m_v = 0;
        end else if (Branch_Taken && m_v) begin
            m_pc = p4 + (32'(signed'(Branch_Offset)) << 2);
            m_ir = 0; m_v = 0;
        end else if (!Stall) begin
            m_ir = mem(m_pc); m_irpc = m_pc; m_v = 1;
            m_pc = m_pc + 32'd4; m_cnt = m_cnt + 32'd1;
        end
        e = '{addr: m_pc, ir: m_ir, ir_pc: m_irpc, valid: m_v,
              cnt: m_cnt, exc_pc: (m_v ? m_irpc : m_pc)};
        sb.push_back(e);
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        clear_in();
        Reset = 1;
        step();
        Reset = 0;
        got = {Addr, IR, IR_PC, IR_Valid, Fetch_Count, Exc_PC};
        exp_o = sb.pop_front();
        checks++;
        if (got !== exp_o) begin
            errors++;
            $display("FAIL reset_sb got %h exp %h", got, exp_o);
        end
        checks++;
        if (Addr !== 32'h0 || IR_Valid !== 1'b0 || Fetch_Count !== 32'h0) begin
            errors++;
            $display("FAIL reset_state addr %h v %b cnt %0d exp 0/0/0",
                     Addr, IR_Valid, Fetch_Count);
        end
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 3; i++) begin
            step();
            got = {Addr, IR, IR_PC, IR_Valid, Fetch_Count, Exc_PC};
            exp_o = sb.pop_front();
            checks++;
            if (got !== exp_o) begin
                errors++;
                $display("FAIL seq_%0d got %h exp %h", i, got, exp_o);
            end
        end
        checks++;
        if (Addr !== 32'hC || IR !== 32'h1000_0002 || IR_PC !== 32'h8 ||
            Fetch_Count !== 32'd3) begin
            errors++;
            $display("FAIL seq_end addr %h ir %h irpc %h cnt %0d exp c/10000002/8/3",
                     Addr, IR, IR_PC, Fetch_Count);
        end
    endtask

    task automatic test_stall();
        Stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            got = {Addr, IR, IR_PC, IR_Valid, Fetch_Count, Exc_PC};
            exp_o = sb.pop_front();
            checks++;
            if (got !== exp_o || Addr !== 32'hC || IR !== 32'h1000_0002 ||
                Fetch_Count !== 32'd3) begin
                errors++;
                $display("FAIL stall_%0d got %h exp %h", i, got, exp_o);
            end
        end
        Stall = 0;
        step();
        got = {Addr, IR, IR_PC, IR_Valid, Fetch_Count, Exc_PC};
        exp_o = sb.pop_front();
        checks++;
        if (got !== exp_o || IR_PC !== 32'hC || Addr !== 32'h10) begin
            errors++;
            $display("FAIL stall_release got %h exp %h", got, exp_o);
        end
    endtask

    task automatic test_branch();
        for (int i = 0; i < 2; i++) begin
            step();
            void'(sb.pop_front());
        end
        checks++;
        if (IR_PC !== 32'h14 || IR_Valid !== 1'b1) begin
            errors++;
            $display("FAIL branch_setup irpc %h v %b exp 14/1", IR_PC, IR_Valid);
        end
        Branch_Taken = 1; Branch_Offset = 16'hFFFE;
        step();
        clear_in();
        got = {Addr, IR, IR_PC, IR_Valid, Fetch_Count, Exc_PC};
        exp_o = sb.pop_front();
        checks++;
        if (got !== exp_o || Addr !== 32'h10 || IR !== 32'h0 || IR_Valid !== 1'b0) begin
            errors++;
            $display("FAIL branch_redirect got %h exp %h", got, exp_o);
        end
        step();
        got = {Addr, IR, IR_PC, IR_Valid, Fetch_Count, Exc_PC};
        exp_o = sb.pop_front();
        checks++;
        if (got !== exp_o || IR !== 32'h1000_0004 || IR_PC !== 32'h10) begin
            errors++;
            $display("FAIL branch_target got %h exp %h", got, exp_o);
        end
    endtask

    task automatic test_exception();
        Reset = 1;
        step();
        void'(sb.pop_front());
        Reset = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            void'(sb.pop_front());
        end
        checks++;
        if (Addr !== 32'h20 || Exc_PC !== 32'h1C) begin
            errors++;
            $display("FAIL exc_pc_before addr %h exc_pc %h exp 20/1c", Addr, Exc_PC);
        end
        Exc_Req = 1; Stall = 1; Branch_Taken = 1; Branch_Offset = 16'h0004;
        step();
        clear_in();
        got = {Addr, IR, IR_PC, IR_Valid, Fetch_Count, Exc_PC};
        exp_o = sb.pop_front();
        checks++;
        if (got !== exp_o || Addr !== 32'h8 || IR_Valid !== 1'b0 || Exc_PC !== 32'h8) begin
            errors++;
            $display("FAIL exc_taken got %h exp %h", got, exp_o);
        end
        step();
        void'(sb.pop_front());
        Eret = 1; EPC_In = 32'h0000_0023;
        step();
        clear_in();
        got = {Addr, IR, IR_PC, IR_Valid, Fetch_Count, Exc_PC};
        exp_o = sb.pop_front();
        checks++;
        if (got !== exp_o || Addr !== 32'h20 || IR_Valid !== 1'b0) begin
            errors++;
            $display("FAIL eret got %h exp %h", got, exp_o);
        end
    endtask

    task automatic test_jump();
        step();
        void'(sb.pop_front());
        Eret = 1; EPC_In = 32'h1000_000B;
        step();
        clear_in();
        void'(sb.pop_front());
        step();
        void'(sb.pop_front());
        checks++;
        if (IR_PC !== 32'h1000_0008 || IR_Valid !== 1'b1) begin
            errors++;
            $display("FAIL jump_setup irpc %h v %b exp 10000008/1", IR_PC, IR_Valid);
        end
        Jump = 1; Jump_Target = 26'h0000040;
        step();
        clear_in();
        got = {Addr, IR, IR_PC, IR_Valid, Fetch_Count, Exc_PC};
        exp_o = sb.pop_front();
        checks++;
        if (got !== exp_o || Addr !== 32'h1000_0100 || IR_Valid !== 1'b0) begin
            errors++;
            $display("FAIL jump_redirect got %h exp %h", got, exp_o);
        end
        step();
        got = {Addr, IR, IR_PC, IR_Valid, Fetch_Count, Exc_PC};
        exp_o = sb.pop_front();
        checks++;
        if (got !== exp_o || IR_PC !== 32'h1000_0100 || IR !== 32'h1400_0040) begin
            errors++;
            $display("FAIL jump_target got %h exp %h", got, exp_o);
        end
    endtask

    task automatic test_wrap();
        Eret = 1; EPC_In = 32'hFFFF_FFFC;
        step();
        clear_in();
        void'(sb.pop_front());
        step();
        got = {Addr, IR, IR_PC, IR_Valid, Fetch_Count, Exc_PC};
        exp_o = sb.pop_front();
        checks++;
        if (got !== exp_o || Addr !== 32'h0 || IR_PC !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL pc_wrap got %h exp %h", got, exp_o);
        end
        Branch_Taken = 1; Branch_Offset = 16'h0001;
        step();
        clear_in();
        got = {Addr, IR, IR_PC, IR_Valid, Fetch_Count, Exc_PC};
        exp_o = sb.pop_front();
        checks++;
        if (got !== exp_o || Addr !== 32'h4) begin
            errors++;
            $display("FAIL branch_wrap got %h exp %h", got, exp_o);
        end
    endtask

    task automatic test_reset_collision();
        Reset = 1; Jump = 1; Jump_Target = 26'h3FF_FFFF;
        step();
        Reset = 0;
        got = {Addr, IR, IR_PC, IR_Valid, Fetch_Count, Exc_PC};
        exp_o = sb.pop_front();
        checks++;
        if (got !== exp_o || Addr !== 32'h0 || IR_Valid !== 1'b0 || Fetch_Count !== 32'h0) begin
            errors++;
            $display("FAIL reset_jump got %h exp %h", got, exp_o);
        end
        step();
        clear_in();
        got = {Addr, IR, IR_PC, IR_Valid, Fetch_Count, Exc_PC};
        exp_o = sb.pop_front();
        checks++;
        if (got !== exp_o || Addr !== 32'h4 || IR_Valid !== 1'b1 || Fetch_Count !== 32'd1) begin
            errors++;
            $display("FAIL jump_in_bubble got %h exp %h", got, exp_o);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        m_pc = 0; m_ir = 0; m_irpc = 0; m_v = 0; m_cnt = 0;
        clear_in();
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_exception();
        test_jump();
        test_wrap();
        test_reset_collision();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left %0d exp 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Instruction-fetch initiator for the single-cycle-with-interrupts CPU; drives the word address into the combinational instruction memory and captures the returned word.
- Holds the PC and a one-deep fetch register (IR, IR_PC, IR_Valid).
- Selects the next PC from five sources: sequential, branch, jump, exception vector, and ERET return.
- Sits between the instruction memory and the decode/control logic; the CP0 logic supplies exception and ERET requests.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- EXC_VECTOR, 32'h0000_0008, PC loaded when an exception or interrupt is taken.

Ports:
- Clk  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Stall  in  1  hold PC and fetch register.
- Branch_Taken  in  1  branch in IR resolved taken.
- Branch_Offset  in  16  raw immediate of branch in IR.
- Jump  in  1  J/JAL in IR.
- Jump_Target  in  26  instr_index of jump in IR.
- Exc_Req  in  1  take exception or interrupt.
- Eret  in  1  return from exception.
- EPC_In  in  32  return address from CP0.
- Inst_In  in  32  word returned by instruction memory for Addr.
- Addr  out  32  fetch address; equals PC (combinational).
- IR  out  32  fetched instruction register.
- IR_PC  out  32  address IR was fetched from.
- IR_Valid  out  1  IR holds a real instruction (0 = bubble).
- Exc_PC  out  32  PC to save as EPC: IR_PC if IR_Valid, else PC.
- Fetch_Count  out  32  number of valid instructions captured since reset.

Behaviour:
- Reset (Reset=1 at edge, overrides everything):
  - PC<=RESET_PC; IR<=0; IR_PC<=0; IR_Valid<=0; Fetch_Count<=0.
  - Addr therefore reads RESET_PC in the cycle after reset.
  - Reset asserted mid-redirect or mid-stall discards that event.
- Next-PC priority, highest first: Exc_Req > Eret > Jump > Branch_Taken > Stall > sequential.
- Redirect values (every redirect ignores Stall and flushes):
  - Exc_Req: PC<=EXC_VECTOR.
  - Eret: PC<={EPC_In[31:2],2'b00}; EPC_In low bits are ignored.
  - Jump: PC<={IR_PC_plus4[31:28],Jump_Target,2'b00}.
  - Branch_Taken: PC<=IR_PC+4+(sign_extend(Branch_Offset)<<2).
  - IR_PC_plus4 = IR_PC+4; all adds are 32-bit modulo 2^32, so 32'hFFFF_FFFC+4 wraps to 0.
- Flush on redirect: IR<=32'h0000_0000 (NOP); IR_Valid<=0; IR_PC unchanged; Fetch_Count unchanged.
- Jump/Branch_Taken/Eret are qualified by IR_Valid; if IR_Valid=0 they are ignored. Exc_Req is never qualified.
- Stall (and no redirect): PC, IR, IR_PC, IR_Valid, and Fetch_Count all hold.
- Sequential (no redirect, no stall):
  - IR<=Inst_In; IR_PC<=PC; IR_Valid<=1; PC<=PC+4; Fetch_Count<=Fetch_Count+1, wrapping at 2^32.
- Latency: the word at Addr appears on IR one cycle later.
- After a redirect, exactly one bubble (IR_Valid=0) follows before the target instruction is in IR.
- Simultaneous events: only the highest-priority event has effect. Example: Exc_Req with Jump goes to EXC_VECTOR, and the jump is lost.
- Addr[1:0] is always 2'b00.
- Exc_PC is purely combinational.

Test Plan:
- Reset, then 4 free-running cycles with memory word n = 32'h1000_0000+n -> Addr 0,4,8,C; IR values 32'h1000_0000..32'h1000_0002 with IR_PC 0,4,8; Fetch_Count=3 after 4 edges.
- IR_PC=32'h14, IR_Valid=1, Branch_Taken=1, Branch_Offset=16'hFFFE -> next PC=32'h10; IR=0, IR_Valid=0; next edge IR=mem[0x10], IR_PC=32'h10.
- IR_PC=32'h1000_0008, Jump=1, Jump_Target=26'h0000040 -> PC=32'h1000_0100; one bubble follows.
- Exc_Req=1 together with Stall=1 and Branch_Taken=1 at PC=32'h20 -> PC=32'h8, IR_Valid=0; Exc_PC sampled beforehand equals IR_PC. Then Eret=1 with EPC_In=32'h0000_0023 -> PC=32'h20.
- Stall held 3 cycles at PC=32'h0C -> Addr, IR, and Fetch_Count all constant. Release -> sequential resumes from 32'h0C.
- Reset asserted in the same cycle as Jump=1 -> PC=RESET_PC, IR_Valid=0, Fetch_Count=0. Jump with IR_Valid=0 -> ignored; PC advances by 4.
